// File: rtl/aes_inv_pkg.sv
// Shared types and GF(2^8) helpers for the byte-serial AES inverse cipher.
//   NB/NC    : state bytes / state columns
//   state_t  : datapath FSM states
//   xtime, gmul, inv_mix_col, isr_idx : arithmetic and addressing helpers
package aes_inv_pkg;

  localparam int unsigned NB = 16;
  localparam int unsigned NC = 4;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    ROUND  = 2'd1,
    MIXCOL = 2'd2,
    OUT    = 2'd3
  } state_t;

  // Multiply by x modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Column packed row 0 in [31:24] down to row 3 in [7:0].
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  // InvShiftRows source: byte (row r, col c) comes from (row r, col c-r mod 4).
  function automatic logic [3:0] isr_idx(input logic [3:0] i);
    logic [1:0] sc;
    sc = i[3:2] - i[1:0];
    return {sc, i[1:0]};
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box: inverse affine map followed by GF(2^8) inversion.
//   x : input byte
//   y : InvSbox(x)
module aes_inv_sbox
  import aes_inv_pkg::*;
(
  input  logic [7:0] x,
  output logic [7:0] y
);

  // a^254 = product of a^(2^k) for k = 1..7; maps 0 to 0 as required.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  logic [7:0] aff;

  always_comb begin
    aff = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    y   = gf_inv(aff);
  end

endmodule

// File: rtl/aes_inv_data_path.sv
// Byte-serial AES inverse cipher with valid/ready streams for ciphertext,
// round keys (K[NR] first) and plaintext. One block in flight.
//   clk, rst              : clock, synchronous active-high reset
//   d_in/din_valid/ready  : ciphertext bytes, state order
//   rk_in/rk_valid/ready  : round-key bytes, 16*(NR+1) per block
//   d_out/dout_valid/ready: plaintext bytes, state order
//   busy                  : block in progress
module aes_inv_data_path
  import aes_inv_pkg::*;
#(
  parameter int unsigned NR = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] d_in,
  input  logic       din_valid,
  output logic       din_ready,
  input  logic [7:0] rk_in,
  input  logic       rk_valid,
  output logic       rk_ready,
  output logic [7:0] d_out,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       busy
);

  localparam int unsigned IW = $clog2(NB);
  localparam int unsigned CW = $clog2(NC);
  localparam int unsigned RW = 4;

  state_t        state;
  logic [7:0]    s [NB];
  logic [7:0]    t [NB];
  logic [IW-1:0] idx;
  logic [CW-1:0] col;
  logic [RW-1:0] rnd;

  logic [7:0]    sb_in;
  logic [7:0]    sb_out;
  logic [31:0]   mc_in;
  logic [31:0]   mc_out;

  // Round datapath: InvShiftRows addressing feeding the inverse S-box.
  assign sb_in = s[isr_idx(idx)];

  aes_inv_sbox u_sbox (
    .x(sb_in),
    .y(sb_out)
  );

  // Column currently being InvMixColumn'd from t back into s.
  always_comb begin
    mc_in  = {t[{col, 2'd0}], t[{col, 2'd1}], t[{col, 2'd2}], t[{col, 2'd3}]};
    mc_out = inv_mix_col(mc_in);
  end

  // Handshake decode; LOAD pairs each ciphertext byte with a key byte.
  always_comb begin
    din_ready  = 1'b0;
    rk_ready   = 1'b0;
    dout_valid = 1'b0;
    case (state)
      LOAD:    begin
        din_ready = rk_valid;
        rk_ready  = din_valid;
      end
      ROUND:   rk_ready   = 1'b1;
      OUT:     dout_valid = 1'b1;
      default: ;
    endcase
  end

  assign d_out = t[idx];
  assign busy  = (state != LOAD) || (idx != '0);

  // Sequencer and state/round storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      idx   <= '0;
      col   <= '0;
      rnd   <= '0;
      for (int unsigned i = 0; i < NB; i++) begin
        s[i] <= 8'h00;
        t[i] <= 8'h00;
      end
    end else begin
      case (state)
        LOAD: begin
          if (din_valid && rk_valid) begin
            s[idx] <= d_in ^ rk_in;
            idx    <= idx + IW'(1);
            if (idx == IW'(NB - 1)) begin
              rnd   <= RW'(NR - 1);
              state <= ROUND;
            end
          end
        end
        ROUND: begin
          if (rk_valid) begin
            t[idx] <= sb_out ^ rk_in;
            idx    <= idx + IW'(1);
            if (idx == IW'(NB - 1)) begin
              if (rnd != '0) begin
                col   <= '0;
                state <= MIXCOL;
              end else begin
                state <= OUT;
              end
            end
          end
        end
        MIXCOL: begin
          s[{col, 2'd0}] <= mc_out[31:24];
          s[{col, 2'd1}] <= mc_out[23:16];
          s[{col, 2'd2}] <= mc_out[15:8];
          s[{col, 2'd3}] <= mc_out[7:0];
          col <= col + CW'(1);
          if (col == CW'(NC - 1)) begin
            rnd   <= rnd - RW'(1);
            idx   <= '0;
            state <= ROUND;
          end
        end
        OUT: begin
          if (dout_ready) begin
            idx <= idx + IW'(1);
            if (idx == IW'(NB - 1)) state <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_data_path.sv
// Directed bench for aes_inv_data_path: FIPS-197 vectors at NR=10 and NR=14,
// key/output stalls, back-to-back blocks and reset mid-round.
module tb_aes_inv_data_path;

  logic       clk;
  logic       rst;
  logic       sel;
  logic [7:0] d_in, rk_in;
  logic       din_valid, rk_valid, dout_ready;
  logic       din_ready, rk_ready, dout_valid, busy;
  logic [7:0] d_out;

  logic       dr10, rr10, dv10, b10, dr14, rr14, dv14, b14;
  logic [7:0] do10, do14;

  aes_inv_data_path #(.NR(10)) dut10 (
    .clk(clk), .rst(rst),
    .d_in(d_in), .din_valid(din_valid & ~sel), .din_ready(dr10),
    .rk_in(rk_in), .rk_valid(rk_valid & ~sel), .rk_ready(rr10),
    .d_out(do10), .dout_valid(dv10), .dout_ready(dout_ready & ~sel),
    .busy(b10)
  );

  aes_inv_data_path #(.NR(14)) dut14 (
    .clk(clk), .rst(rst),
    .d_in(d_in), .din_valid(din_valid & sel), .din_ready(dr14),
    .rk_in(rk_in), .rk_valid(rk_valid & sel), .rk_ready(rr14),
    .d_out(do14), .dout_valid(dv14), .dout_ready(dout_ready & sel),
    .busy(b14)
  );

  assign din_ready  = sel ? dr14 : dr10;
  assign rk_ready   = sel ? rr14 : rr10;
  assign dout_valid = sel ? dv14 : dv10;
  assign busy       = sel ? b14  : b10;
  assign d_out      = sel ? do14 : do10;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0]   ek [2][240];
  logic [127:0] ct_q [2];
  logic [127:0] pt_q [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Key-schedule model (forward S-box built from GF inverse + affine map).
  function automatic logic [7:0] tmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] tinv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    for (int c = 1; c < 256; c++)
      if (tmul(a, 8'(c)) == 8'h01) r = 8'(c);
    return r;
  endfunction

  function automatic logic [7:0] tsbox(input logic [7:0] x);
    logic [7:0] b;
    b = tinv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {tsbox(w[31:24]), tsbox(w[23:16]), tsbox(w[15:8]), tsbox(w[7:0])};
  endfunction

  task automatic expand(input int slot, input logic [255:0] key, input int nk, input int nr);
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4 * nk; i++) ek[slot][i] = key[255 - 8 * i -: 8];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      tmp = {ek[slot][4*(i-1)], ek[slot][4*(i-1)+1], ek[slot][4*(i-1)+2], ek[slot][4*(i-1)+3]};
      if (i % nk == 0) begin
        tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subword(tmp);
      end
      for (int b = 0; b < 4; b++) ek[slot][4*i+b] = ek[slot][4*(i-nk)+b] ^ tmp[31 - 8 * b -: 8];
    end
  endtask

  // Streams nblk blocks through the selected DUT and checks every output byte.
  task automatic run(input int nr, input int nblk, input int gap_rk, input int gap_out,
                     input int abort_at, input string tag);
    int   di, ki, oi, nkb, last_load, stalls, handoff, t0, j, r;
    logic waiting, rk_hold, f_din, f_rk;
    di = 0; ki = 0; oi = 0; nkb = 16 * (nr + 1);
    last_load = 0; stalls = 0; handoff = -10; t0 = cyc;
    waiting = 1'b0; rk_hold = 1'b0;
    while (oi < 16 * nblk) begin
      if (cyc - t0 > 4000) begin
        chk({tag, "_timeout"}, 32'(oi), 32'(16 * nblk));
        break;
      end
      @(negedge clk);
      din_valid = (di < 16 * nblk);
      d_in      = 8'h00;
      if (di < 16 * nblk) d_in = ct_q[di / 16][127 - 8 * (di % 16) -: 8];
      rk_valid  = (ki < nkb * nblk) && (rk_hold || $urandom_range(99) >= 32'(gap_rk));
      rk_in     = 8'h00;
      if (ki < nkb * nblk) begin
        j     = ki % nkb;
        r     = nr - j / 16;
        rk_in = ek[ki / nkb][16 * r + j % 16];
      end
      dout_ready = ($urandom_range(99) >= 32'(gap_out));
      #1;
      f_din = din_valid && din_ready;
      f_rk  = rk_valid && rk_ready;
      if (waiting && rk_ready && !rk_valid) stalls++;
      if (dout_valid && waiting) begin
        chk({tag, "_latency"}, 32'(cyc - last_load), 32'(17 + (nr - 1) * 20 + stalls));
        waiting = 1'b0;
      end
      if (dout_valid) begin
        chk({tag, "_din_ready_in_out"}, 32'(din_ready), 32'd0);
        chk({tag, "_busy_in_out"}, 32'(busy), 32'd1);
      end
      if (cyc == handoff + 1) begin
        chk({tag, "_handoff_busy_low"}, 32'(busy), 32'd0);
        if (rk_valid) chk({tag, "_handoff_din_ready"}, 32'(din_ready), 32'd1);
      end
      if (cyc == handoff + 2) chk({tag, "_handoff_busy_high"}, 32'(busy), 32'd1);
      if (f_din) begin
        di++;
        if (di % 16 == 0) begin
          last_load = cyc;
          waiting   = 1'b1;
          stalls    = 0;
        end
      end
      if (f_rk) ki++;
      rk_hold = rk_valid && !f_rk;
      if (dout_valid && dout_ready) begin
        chk({tag, "_byte"}, 32'(d_out), 32'(pt_q[oi / 16][127 - 8 * (oi % 16) -: 8]));
        oi++;
        if (oi % 16 == 0 && oi < 16 * nblk) handoff = cyc;
      end
      if (abort_at > 0 && waiting && cyc == last_load + abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; din_valid = 1'b0; rk_valid = 1'b1; dout_ready = 1'b1;
        #1;
        chk({tag, "_rst_dout_valid"}, 32'(dout_valid), 32'd0);
        chk({tag, "_rst_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rst_din_ready"}, 32'(din_ready), 32'd1);
        chk({tag, "_rst_rk_ready"}, 32'(rk_ready), 32'd0);
        @(negedge clk);
        rk_valid = 1'b0;
        return;
      end
    end
    @(negedge clk);
    din_valid = 1'b0; rk_valid = 1'b0;
    #1;
    chk({tag, "_end_busy"}, 32'(busy), 32'd0);
    chk({tag, "_end_dout_valid"}, 32'(dout_valid), 32'd0);
    chk({tag, "_keys_used"}, 32'(ki), 32'(nkb * nblk));
  endtask

  localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    rst = 1'b1; sel = 1'b0;
    d_in = 8'h00; rk_in = 8'h00;
    din_valid = 1'b0; rk_valid = 1'b0; dout_ready = 1'b0;
    repeat (3) @(negedge clk);
    din_valid = 1'b1;
    #1;
    chk("reset_dout_valid", 32'(dout_valid), 32'd0);
    chk("reset_d_out", 32'(d_out), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rk_ready", 32'(rk_ready), 32'd1);
    chk("reset_din_ready", 32'(din_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0; din_valid = 1'b0; rk_valid = 1'b1;
    #1;
    chk("post_reset_din_ready", 32'(din_ready), 32'd1);
    chk("post_reset_rk_ready", 32'(rk_ready), 32'd0);
    chk("post_reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rk_valid = 1'b0;

    expand(0, KEY_C1, 4, 10);
    ct_q[0] = CT_C1; pt_q[0] = PT_C;
    run(10, 1, 0, 0, 0, "c1");

    expand(0, KEY_B, 4, 10);
    ct_q[0] = CT_B; pt_q[0] = PT_B;
    run(10, 1, 0, 0, 0, "appb");

    expand(0, KEY_C1, 4, 10);
    ct_q[0] = CT_C1; pt_q[0] = PT_C;
    run(10, 1, 30, 30, 0, "stall");

    expand(1, KEY_B, 4, 10);
    ct_q[1] = CT_B; pt_q[1] = PT_B;
    run(10, 2, 0, 0, 0, "b2b");

    run(10, 1, 0, 0, 88, "abort");
    run(10, 1, 0, 0, 0, "after_abort");

    sel = 1'b1;
    @(negedge clk);
    expand(0, KEY_C3, 8, 14);
    ct_q[0] = CT_C3; pt_q[0] = PT_C;
    run(14, 1, 0, 0, 0, "c3");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_inv_data_path.md
Name: aes_inv_data_path

Overview:
Byte-serial AES inverse-cipher engine, the decrypt-direction counterpart of the 8-bit encrypt datapath. It accepts a 16-byte ciphertext block and a stream of round-key bytes in decrypt order (K[NR] first, K[0] last) and emits 16 plaintext bytes. All three streams use valid/ready handshakes. One block is in flight at a time, and round keys come from an external key-schedule block.

Parameters:
NR, 10, number of rounds; 10/12/14 supported (AES-128/192/256), because keys are supplied externally.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
d_in  input  8  ciphertext byte, state order (byte i = row i%4, col i/4)
din_valid  input  1  d_in valid
din_ready  output  1  d_in accepted when din_valid & din_ready
rk_in  input  8  round-key byte, same byte order; sequence K[NR]..K[0], 16*(NR+1) bytes per block
rk_valid  input  1  rk_in valid
rk_ready  output  1  rk_in consumed when rk_valid & rk_ready
d_out  output  8  plaintext byte, state order
dout_valid  output  1  d_out valid
dout_ready  input  1  sink ready
busy  output  1  high from first accepted input byte until the 16th output byte transfers

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. Reset is sampled only on the rising edge of clk.
- Storage:
  - s[0:15]: work state.
  - t[0:15]: round output.
  - 4-bit byte index idx, 2-bit column index col, round counter rnd.
- FSM states: LOAD, ROUND, MIXCOL, OUT.
- LOAD:
  - din_ready = rk_valid; rk_ready = din_valid. Valids must not depend on readies.
  - On din_valid & rk_valid: s[idx] <= d_in ^ rk_in, idx++.
  - After byte 15: idx <= 0, rnd <= NR-1, go to ROUND.
- ROUND:
  - rk_ready = 1.
  - Per cycle with rk_valid: t[idx] <= InvSbox(s[isr(idx)]) ^ rk_in, where isr(idx) = row r, col (c - r) mod 4 (InvShiftRows source).
  - idx++ per step. !rk_valid stalls the cycle with no state change.
  - After byte 15: if rnd != 0, go to MIXCOL with col <= 0; if rnd == 0, go to OUT.
- MIXCOL:
  - One column per cycle, no key use: s[4col..4col+3] <= InvMixColumn(t[4col..4col+3]).
  - Coefficients {0e,0b,0d,09} in GF(2^8), polynomial 0x11B.
  - After col 3: rnd--, idx <= 0, go to ROUND.
- OUT:
  - dout_valid = 1, d_out = t[idx] (registered storage, combinational select).
  - On dout_ready: idx++. After byte 15 transfers, go to LOAD, idx <= 0, busy drops.
- Ready/valid outside their states:
  - din_ready is 0 in ROUND/MIXCOL/OUT; din_valid there is ignored.
  - rk_ready is 0 in MIXCOL/OUT.
  - dout_valid is 0 outside OUT.
- Latency with no stalls:
  - ROUND+MIXCOL occupy 16 + (NR-1)*20 cycles (196 for NR=10) after the 16th load transfer.
  - dout_valid rises in the next cycle.
  - Stalls on rk_valid/dout_ready add exactly the stalled cycles.
- Reset values:
  - FSM=LOAD, idx=col=0, rnd=0, s and t cleared.
  - dout_valid=0, d_out=0x00, busy=0, rk_ready=0 unless din_valid.
  - din_ready follows rk_valid from the first post-reset cycle.
- Reset mid-operation (any state): block discarded, no partial output, state as above. The key source must also restart.
- Simultaneous dout transfer of byte 15 and din_valid: input is not accepted until the next cycle (LOAD).

Decomposition:
- Package aes_inv_pkg:
  - state enum, NB=16, NC=4.
  - functions xtime, gmul(a,b), inv_mix_col(32b)->32b, isr_idx(4b)->4b.
- Sub-module aes_inv_sbox: 8-bit combinational inverse S-box (table or composite-field), ports (x, y).

Test Plan:
- FIPS-197 C.1:
  - Stimulus: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a; key stream for key 000102030405060708090a0b0c0d0e0f, K10 = 13111d7fe3944a17f307a78b4d2b30c5 first.
  - Response: d_out bytes 00,11,22..ff. First dout_valid 197 cycles after the last load transfer.
- FIPS-197 App.B:
  - Stimulus: ciphertext 3925841d02dc09fbdc118597196a0b32, key 2b7e151628aed2a6abf7158809cf4f3c.
  - Response: plaintext 3243f6a8885a308d313198a2e0370734.
- Stalls: random rk_valid gaps (~30%) and dout_ready gaps during C.1 -> identical plaintext. Latency grows by the stall count; no byte duplicated or lost.
- Back-to-back: second ciphertext presented during OUT.
  - din_ready stays 0 until the cycle after byte 15 transfers.
  - Second block decrypts correctly; busy low for exactly the handoff cycle, or stays high if the next byte is accepted immediately.
- Reset in ROUND (rnd=5, idx=7):
  - Next cycle: dout_valid=0, busy=0, FSM=LOAD.
  - A fresh C.1 block then yields 00..ff.
- NR=14 build: AES-256 FIPS-197 C.3.
  - Stimulus: ciphertext 8ea2b7ca516745bfeafc49904b496089 with its 240-byte key stream.
  - Response: plaintext 00112233445566778899aabbccddeeff.
